// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the fetch PC sequencer
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DRAIN    = 2'd3
    } pc_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INCR   = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - next-PC priority select: trap > branch > pc+4 > hold
module pc_next_mux
    import pc_seq_pkg::*;
(
    input  logic        trap_i,
    input  logic [31:0] trap_addr_i,
    input  logic        branch_i,
    input  logic [31:0] target_addr_i,
    input  logic        advance_i,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o,
    output logic        redirect_o
);

    always_comb begin
        pc_next_o  = pc_i;
        redirect_o = trap_i | branch_i;
        if (trap_i) begin
            pc_next_o = word_align(trap_addr_i);
        end else if (branch_i) begin
            pc_next_o = word_align(target_addr_i);
        end else if (advance_i) begin
            pc_next_o = pc_i + PC_INCR;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction fetch sequencer with one outstanding request and redirect drain
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] target_addr_in,
    input  logic        trap_in,
    input  logic [31:0] trap_addr_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_ready_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out,
    output logic        instr_valid_out,
    output logic        flush_out
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic        flush_q;

    logic live, redirect, rsp_ok, load, consume, req, accept;

    // Redirects are ignored during the boot cycle.
    assign live    = (state_q != ST_BOOT);
    assign rsp_ok  = (state_q == ST_WAIT_RSP) && imem_rvalid_in;
    assign load    = rsp_ok && !redirect;
    assign consume = valid_q && !stall_in;
    // No request in the flush cycle so a redirect address is issued only after flush_out.
    assign req     = (state_q == ST_FETCH) && (!valid_q || !stall_in) && !flush_q;
    assign accept  = req && imem_ready_in;

    pc_next_mux u_pc_next_mux (
        .trap_i        (trap_in && live),
        .trap_addr_i   (trap_addr_in),
        .branch_i      (branch_taken_in && live),
        .target_addr_i (target_addr_in),
        .advance_i     (rsp_ok),
        .pc_i          (pc_q),
        .pc_next_o     (pc_d),
        .redirect_o    (redirect)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT:     state_d = ST_FETCH;
            ST_FETCH:    if (accept) state_d = redirect ? ST_DRAIN : ST_WAIT_RSP;
            ST_WAIT_RSP: begin
                if (imem_rvalid_in) state_d = ST_FETCH;
                else if (redirect)  state_d = ST_DRAIN;
            end
            ST_DRAIN:    if (imem_rvalid_in) state_d = ST_FETCH;
            default:     state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        if (redirect) begin
            valid_d = 1'b0;
        end else if (load) begin
            instr_d    = imem_rdata_in;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            flush_q    <= redirect;
        end
    end

    assign imem_req_out    = req;
    assign imem_addr_out   = pc_q;
    assign instr_out       = instr_q;
    assign instr_pc_out    = instr_pc_q;
    assign instr_valid_out = valid_q;
    assign flush_out       = flush_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk;
    logic        reset_in;
    logic        stall_in;
    logic        branch_taken_in;
    logic [31:0] target_addr_in;
    logic        trap_in;
    logic [31:0] trap_addr_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ready_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_valid_out;
    logic        flush_out;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk_in          (clk),
        .reset_in        (reset_in),
        .stall_in        (stall_in),
        .branch_taken_in (branch_taken_in),
        .target_addr_in  (target_addr_in),
        .trap_in         (trap_in),
        .trap_addr_in    (trap_addr_in),
        .imem_req_out    (imem_req_out),
        .imem_addr_out   (imem_addr_out),
        .imem_ready_in   (imem_ready_in),
        .imem_rvalid_in  (imem_rvalid_in),
        .imem_rdata_in   (imem_rdata_in),
        .instr_out       (instr_out),
        .instr_pc_out    (instr_pc_out),
        .instr_valid_out (instr_valid_out),
        .flush_out       (flush_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // memory model state
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    int          lat_min = 1;
    int          lat_max = 1;
    logic        rand_ready = 1'b0;

    // reference model state
    logic [31:0] exp_pc = RST_PC;
    logic        flush_exp = 1'b0;
    int          since = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_instr = 32'h0;
    logic [31:0] hold_pc = 32'h0;
    logic        last_accept = 1'b0;
    logic [31:0] last_addr = 32'h0;
    int          consumed = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample/check at negedge, then drive memory outputs just after posedge.
    task automatic step();
        logic acc, rdir, boot, cons;
        @(negedge clk);
        acc = imem_req_out & imem_ready_in;
        last_accept = acc;
        last_addr = imem_addr_out;
        if (reset_in) begin
            since = 0;
            mem_busy = 1'b0;
            exp_pc = RST_PC;
            flush_exp = 1'b0;
            hold_prev = 1'b0;
        end else begin
            since = (since < 10) ? since + 1 : since;
            boot = (since == 1);
            if (boot) chk("boot_no_req", 32'(imem_req_out), 32'd0);
            chk("flush_pulse", 32'(flush_out), 32'(flush_exp));
            if (flush_out) begin
                chk("flush_valid_low", 32'(instr_valid_out), 32'd0);
                chk("flush_no_req", 32'(imem_req_out), 32'd0);
            end
            if (hold_prev) begin
                chk("stall_hold_valid", 32'(instr_valid_out), 32'd1);
                chk("stall_hold_instr", instr_out, hold_instr);
                chk("stall_hold_pc", instr_pc_out, hold_pc);
            end
            if (imem_rvalid_in) mem_busy = 1'b0;
            if (acc) begin
                chk("one_outstanding", 32'(mem_busy), 32'd0);
                mem_busy = 1'b1;
                mem_cnt = int'($urandom_range(lat_min, lat_max));
                mem_addr = imem_addr_out;
            end
            cons = instr_valid_out & ~stall_in;
            if (cons) begin
                chk("consume_pc", instr_pc_out, exp_pc);
                chk("consume_instr", instr_out, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            rdir = (trap_in | branch_taken_in) & ~boot;
            hold_prev = instr_valid_out & stall_in & ~rdir;
            hold_instr = instr_out;
            hold_pc = instr_pc_out;
            flush_exp = rdir;
            if (rdir) exp_pc = (trap_in ? trap_addr_in : target_addr_in) & 32'hFFFF_FFFC;
        end
        @(posedge clk);
        #1;
        imem_rvalid_in = 1'b0;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid_in = 1'b1;
                imem_rdata_in = memf(mem_addr);
            end
        end
        imem_ready_in = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic expect_fetch(input string name, input logic [31:0] exp_addr, input logic check_addr);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_accept && n < 40);
        if (!last_accept || !check_addr) chk(name, 32'(last_accept), 32'd1);
        else chk(name, last_addr, exp_addr);
    endtask

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] ipc;
    } vec_t;

    vec_t tv[13];
    int   cons_start;

    initial begin
        tv[0]  = '{1'b0, 1'b0, 32'h100, 1'b0, 32'h0};
        tv[1]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0};
        tv[2]  = '{1'b0, 1'b0, 32'h100, 1'b0, 32'h0};
        tv[3]  = '{1'b0, 1'b1, 32'h104, 1'b1, 32'h100};
        tv[4]  = '{1'b0, 1'b0, 32'h104, 1'b0, 32'h0};
        tv[5]  = '{1'b1, 1'b0, 32'h108, 1'b1, 32'h104};
        tv[6]  = '{1'b1, 1'b0, 32'h108, 1'b1, 32'h104};
        tv[7]  = '{1'b1, 1'b0, 32'h108, 1'b1, 32'h104};
        tv[8]  = '{1'b1, 1'b0, 32'h108, 1'b1, 32'h104};
        tv[9]  = '{1'b1, 1'b0, 32'h108, 1'b1, 32'h104};
        tv[10] = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h104};
        tv[11] = '{1'b0, 1'b0, 32'h108, 1'b0, 32'h0};
        tv[12] = '{1'b0, 1'b1, 32'h10C, 1'b1, 32'h108};

        reset_in = 1'b1;
        stall_in = 1'b0;
        branch_taken_in = 1'b0;
        target_addr_in = 32'h0;
        trap_in = 1'b0;
        trap_addr_in = 32'h0;
        imem_ready_in = 1'b1;
        imem_rvalid_in = 1'b0;
        imem_rdata_in = 32'h0;

        // reset values
        repeat (3) step();
        chk("rst_req", 32'(imem_req_out), 32'd0);
        chk("rst_addr", imem_addr_out, RST_PC);
        chk("rst_valid", 32'(instr_valid_out), 32'd0);
        chk("rst_instr", instr_out, 32'h0000_0013);
        chk("rst_ipc", instr_pc_out, 32'h0);
        chk("rst_flush", 32'(flush_out), 32'd0);

        // cycle-by-cycle table from reset release, including a 5-cycle stall
        reset_in = 1'b0;
        for (int i = 0; i < 13; i++) begin
            stall_in = tv[i].stall;
            #1;
            chk($sformatf("tv%0d_req", i), 32'(imem_req_out), 32'(tv[i].req));
            chk($sformatf("tv%0d_addr", i), imem_addr_out, tv[i].addr);
            chk($sformatf("tv%0d_valid", i), 32'(instr_valid_out), 32'(tv[i].valid));
            if (tv[i].valid) begin
                chk($sformatf("tv%0d_ipc", i), instr_pc_out, tv[i].ipc);
                chk($sformatf("tv%0d_instr", i), instr_out, memf(tv[i].ipc));
            end
            step();
        end
        stall_in = 1'b0;

        // branch while waiting for a response; returned word is drained
        lat_min = 2;
        lat_max = 2;
        expect_fetch("r037_accept", 32'h0, 1'b0);
        branch_taken_in = 1'b1;
        target_addr_in = 32'h0000_0203;
        step();
        branch_taken_in = 1'b0;
        #1;
        chk("r037_flush", 32'(flush_out), 32'd1);
        chk("r037_valid", 32'(instr_valid_out), 32'd0);
        expect_fetch("r037_next_fetch", 32'h0000_0200, 1'b1);

        // trap wins over simultaneous branch
        lat_min = 1;
        lat_max = 3;
        repeat (3) step();
        trap_in = 1'b1;
        trap_addr_in = 32'h0000_0080;
        branch_taken_in = 1'b1;
        target_addr_in = 32'h0000_0400;
        step();
        trap_in = 1'b0;
        branch_taken_in = 1'b0;
        expect_fetch("r038_trap_fetch", 32'h0000_0080, 1'b1);

        // PC wrap
        repeat (2) step();
        branch_taken_in = 1'b1;
        target_addr_in = 32'hFFFF_FFFE;
        step();
        branch_taken_in = 1'b0;
        expect_fetch("r039_top_fetch", 32'hFFFF_FFFC, 1'b1);
        expect_fetch("r039_wrap_fetch", 32'h0000_0000, 1'b1);

        // reset while waiting for a response
        lat_min = 2;
        lat_max = 2;
        expect_fetch("r040_accept", 32'h0, 1'b0);
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        chk("r040_req", 32'(imem_req_out), 32'd0);
        chk("r040_addr", imem_addr_out, RST_PC);
        chk("r040_valid", 32'(instr_valid_out), 32'd0);
        chk("r040_instr", instr_out, 32'h0000_0013);
        chk("r040_ipc", instr_pc_out, 32'h0);
        chk("r040_flush", 32'(flush_out), 32'd0);
        expect_fetch("r040_restart", RST_PC, 1'b1);

        // randomized traffic against the reference model
        lat_min = 1;
        lat_max = 3;
        rand_ready = 1'b1;
        cons_start = consumed;
        for (int i = 0; i < 1500; i++) begin
            stall_in = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 99) < 5) begin
                branch_taken_in = 1'b1;
                target_addr_in = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom;
                trap_in = ($urandom_range(0, 2) == 0);
                trap_addr_in = $urandom;
            end else begin
                branch_taken_in = 1'b0;
                trap_in = 1'b0;
            end
            reset_in = ($urandom_range(0, 399) == 0);
            step();
        end
        reset_in = 1'b0;
        stall_in = 1'b0;
        branch_taken_in = 1'b0;
        trap_in = 1'b0;
        step();
        chk("random_progress", 32'((consumed - cons_start) > 50), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset (bits [1:0] are 0).
REQ-002 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_in  input  1  reset, synchronous and active-high.
REQ-004 stall_in  input  1  downstream not accepting; holds the presented instruction.
REQ-005 branch_taken_in  input  1  redirect request from the branch unit (already gated for branch/jal/jalr).
REQ-006 target_addr_in  input  32  branch/jump target; sampled when branch_taken_in=1.
REQ-007 trap_in  input  1  trap redirect request; priority over branch_taken_in.
REQ-008 trap_addr_in  input  32  trap vector; sampled when trap_in=1.
REQ-009 imem_req_out  output  1  fetch request valid.
REQ-010 imem_addr_out  output  32  fetch address, word aligned.
REQ-011 imem_ready_in  input  1  memory accepts request this cycle (imem_req_out & imem_ready_in).
REQ-012 imem_rvalid_in  input  1  read data valid; at least 1 cycle after acceptance.
REQ-013 imem_rdata_in  input  32  instruction word.
REQ-014 instr_out  output  32  fetched instruction.
REQ-015 instr_pc_out  output  32  address of instr_out.
REQ-016 instr_valid_out  output  1  instr_out/instr_pc_out valid; consumed when instr_valid_out & !stall_in.
REQ-017 flush_out  output  1  one-cycle pulse on every accepted redirect.

Function
REQ-018 States: BOOT, FETCH, WAIT_RSP, DRAIN; at most one request outstanding.
REQ-019 BOOT: lasts exactly one cycle after reset release, no request, then FETCH with pc=RESET_PC.
REQ-020 FETCH: imem_req_out=1, imem_addr_out=pc, only when output register empty or consumed this cycle; on acceptance go WAIT_RSP.
REQ-021 WAIT_RSP: on imem_rvalid_in load instr_out=rdata, instr_pc_out=pc, instr_valid_out=1, pc<=pc+4, go FETCH.
REQ-022 pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 Output register holds value and instr_valid_out while stall_in=1; clears on consumption if no new data arrives.
REQ-024 Redirect = trap_in | branch_taken_in; address = trap_addr_in if trap_in else target_addr_in, bits [1:0] forced 0.
REQ-025 On redirect: next cycle pc=redirect address, flush_out=1 for that one cycle, instr_valid_out=0, regardless of stall_in.
REQ-026 Redirect in FETCH with request accepted same cycle, or in WAIT_RSP without rvalid -> DRAIN.
REQ-027 Redirect in WAIT_RSP coinciding with imem_rvalid_in: data discarded, go FETCH.
REQ-028 DRAIN: no request; next imem_rvalid_in discarded, then FETCH; a further redirect in DRAIN only updates pc and re-pulses flush_out.
REQ-029 Redirect in BOOT is ignored; redirect in FETCH with no acceptance: stay FETCH at new pc.
REQ-030 Redirect address is presented on imem_addr_out no earlier than the cycle after flush_out.

Reset
REQ-031 While reset_in=1: state=BOOT, pc=RESET_PC, imem_req_out=0, imem_addr_out=RESET_PC, instr_valid_out=0, instr_out=32'h0000_0013, instr_pc_out=0, flush_out=0.
REQ-032 Reset mid-transaction abandons the outstanding request; memory is reset by the same reset_in and returns no stale rvalid.

Structure
REQ-033 Shared package pc_seq_pkg holds state enum, NOP constant 32'h0000_0013, PC increment 4.
REQ-034 One sub-module pc_next_mux: combinational priority select trap > branch > pc+4 > hold.

Verification
REQ-035 Reset, RESET_PC=32'h100, ready=1, rvalid 1 cycle later -> addresses 0x100,0x104,0x108; first instr_valid_out 3 cycles after reset release.
REQ-036 stall_in=1 for 5 cycles with instr at 0x104 valid -> output stable, no new imem_req_out, resumes at 0x108.
REQ-037 branch_taken_in with target 0x203 while WAIT_RSP -> flush_out 1 cycle, DRAIN drops returned word, next fetch at 0x200.
REQ-038 trap_in (vector 0x80) and branch_taken_in (0x400) same cycle -> next fetch 0x80.
REQ-039 pc=0xFFFF_FFFC fetched -> next imem_addr_out 0x0000_0000.
REQ-040 reset_in asserted in WAIT_RSP -> all outputs at reset values next cycle, fetch restarts at RESET_PC.
